// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: Avalon-MM LED sequencer with SW, heartbeat, bounce-chase and blink modes, a step timer and a bounce irq.
// Define LED_PWM_EN to add the global 8-bit PWM brightness dimmer (CTRL[15:8]).
module led_pattern_ctrl #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned NUM_LED = 4
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [1:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    output logic [31:0]        avs_readdata,
    output logic               avs_readdatavalid,
    output logic               avs_waitrequest,
    output logic [NUM_LED-1:0] led_out,
    output logic               irq
);
    localparam int unsigned DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] MODE_SW    = 2'd0;
    localparam logic [1:0] MODE_HB    = 2'd1;
    localparam logic [1:0] MODE_CHASE = 2'd2;
    localparam logic [1:0] MODE_BLINK = 2'd3;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    logic               ctrl_en;
    logic [1:0]         ctrl_mode;
    logic               irq_en;
    logic [NUM_LED-1:0] swval;
    logic [15:0]        period;
    logic [15:0]        bounce_cnt;
    logic [15:0]        cnt_nxt;
    logic               irq_pend;
    logic [PW-1:0]      pre_cnt;
    logic [15:0]        step_cnt;
    logic [15:0]        period_eff;
    dir_t               dir, dir_nxt;
    logic [NUM_LED-1:0] pos, pos_nxt;
    logic               hb, hb_nxt;
    logic               blink_on, blink_nxt;
    logic [NUM_LED-1:0] pattern;
    logic               pwm_on;
    logic [7:0]         brightness_rd;
    logic               wr_ctrl, wr_swval, wr_period, wr_status, rd_en;
    logic               tick, step, restart, adv, bounce;
    logic               clr_pend, clr_cnt;
    logic [31:0]        rd_mux;
    logic               unused_wdata;

    assign avs_waitrequest = 1'b0;
    assign unused_wdata    = ^avs_writedata[30:16];

    assign wr_ctrl   = avs_write && (avs_address == 2'd0);
    assign wr_swval  = avs_write && (avs_address == 2'd1);
    assign wr_period = avs_write && (avs_address == 2'd2);
    assign wr_status = avs_write && (avs_address == 2'd3);
    assign rd_en     = avs_read && !avs_write;
    assign clr_pend  = wr_status && avs_writedata[31];
    assign clr_cnt   = wr_status && (avs_writedata[15:0] != 16'd0);

    // Mode or enable change restarts timing and pattern from a known phase.
    assign restart    = wr_ctrl && ((avs_writedata[0] != ctrl_en) || (avs_writedata[2:1] != ctrl_mode));
    assign tick       = (pre_cnt == PW'(DIV - 1));
    assign period_eff = (period == 16'd0) ? 16'd1 : period;
    assign step       = tick && (step_cnt >= (period_eff - 16'd1));
    assign adv        = step && ctrl_en && !restart;

`ifdef LED_PWM_EN
    logic [7:0] brightness;
    logic [7:0] pwm_cnt;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            brightness <= 8'hFF;
            pwm_cnt    <= 8'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (wr_ctrl) brightness <= avs_writedata[15:8];
        end
    end

    assign pwm_on        = (pwm_cnt < brightness);
    assign brightness_rd = brightness;
`else
    assign pwm_on        = 1'b1;
    assign brightness_rd = 8'h00;
`endif

    // Pattern state register (chase direction FSM plus heartbeat/blink phase).
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            dir      <= DIR_UP;
            pos      <= NUM_LED'(1);
            hb       <= 1'b0;
            blink_on <= 1'b0;
        end else begin
            dir      <= dir_nxt;
            pos      <= pos_nxt;
            hb       <= hb_nxt;
            blink_on <= blink_nxt;
        end
    end

    always_comb begin
        dir_nxt   = dir;
        pos_nxt   = pos;
        hb_nxt    = hb;
        blink_nxt = blink_on;
        bounce    = 1'b0;
        if (restart) begin
            dir_nxt   = DIR_UP;
            pos_nxt   = NUM_LED'(1);
            hb_nxt    = 1'b0;
            blink_nxt = 1'b0;
        end else if (adv) begin
            case (ctrl_mode)
                MODE_HB:    hb_nxt    = ~hb;
                MODE_BLINK: blink_nxt = ~blink_on;
                MODE_CHASE: begin
                    if (dir == DIR_UP) begin
                        pos_nxt = pos << 1;
                        if (pos[NUM_LED-2]) dir_nxt = DIR_UP == DIR_UP ? DIR_DOWN : DIR_UP;
                    end else begin
                        pos_nxt = pos >> 1;
                        if (pos[1]) begin
                            dir_nxt = DIR_UP;
                            bounce  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (ctrl_mode)
            MODE_SW:    pattern = swval;
            MODE_HB:    pattern = {swval[NUM_LED-1:1], hb};
            MODE_CHASE: pattern = pos;
            default:    pattern = {NUM_LED{blink_on}};
        endcase
    end

    // Bounce counter saturates; a same-cycle clear and bounce leaves a count of one.
    always_comb begin
        cnt_nxt = clr_cnt ? 16'd0 : bounce_cnt;
        if (bounce && (cnt_nxt != 16'hFFFF)) cnt_nxt = cnt_nxt + 16'd1;
    end

    always_comb begin
        case (avs_address)
            2'd0:    rd_mux = {16'd0, brightness_rd, 4'd0, irq_en, ctrl_mode, ctrl_en};
            2'd1:    rd_mux = 32'(swval);
            2'd2:    rd_mux = {16'd0, period};
            default: rd_mux = {irq_pend, 15'd0, bounce_cnt};
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            ctrl_en           <= 1'b0;
            ctrl_mode         <= MODE_SW;
            irq_en            <= 1'b0;
            swval             <= '0;
            period            <= 16'd250;
            bounce_cnt        <= 16'd0;
            irq_pend          <= 1'b0;
            pre_cnt           <= '0;
            step_cnt          <= 16'd0;
            led_out           <= '0;
            irq               <= 1'b0;
            avs_readdata      <= 32'd0;
            avs_readdatavalid <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= avs_writedata[0];
                ctrl_mode <= avs_writedata[2:1];
                irq_en    <= avs_writedata[3];
            end
            if (wr_swval)  swval  <= avs_writedata[NUM_LED-1:0];
            if (wr_period) period <= avs_writedata[15:0];

            if (restart) begin
                pre_cnt  <= '0;
                step_cnt <= 16'd0;
            end else begin
                pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
                if (step)      step_cnt <= 16'd0;
                else if (tick) step_cnt <= step_cnt + 16'd1;
            end

            bounce_cnt <= cnt_nxt;
            if (bounce && irq_en) irq_pend <= 1'b1;
            else if (clr_pend)    irq_pend <= 1'b0;

            led_out <= ctrl_en ? (pattern & {NUM_LED{pwm_on}}) : '0;
            irq     <= irq_pend & irq_en;

            avs_readdatavalid <= rd_en;
            if (rd_en) avs_readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed and random register traffic against a sequence-index model of the LED controller.
// Honours LED_PWM_EN the same way the design does.
module tb_led_pattern_ctrl;
    localparam int unsigned N   = 4;
    localparam int unsigned DIV = 1;
    localparam int          CHASE_LEN = 2 * N - 2;

    logic          clk = 1'b0;
    logic          reset_reset = 1'b1;
    logic [1:0]    avs_address = 2'd0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = 32'd0;
    logic [31:0]   avs_readdata;
    logic          avs_readdatavalid;
    logic          avs_waitrequest;
    logic [N-1:0]  led_out;
    logic          irq;

    int checks = 0;
    int failures = 0;

    led_pattern_ctrl #(.CLK_HZ(1000), .TICK_HZ(1000), .NUM_LED(N)) dut (
        .clk_clk(clk), .reset_reset(reset_reset),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest),
        .led_out(led_out), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference state: chase is an index into the repeating bounce sequence.
    bit          m_en, m_irqen, m_pend, m_hb, m_blink, m_irq, m_rvalid;
    int          m_mode, m_bright, m_sw, m_period, m_cnt, m_pcnt, m_scnt, m_idx, m_pwm, m_led;
    int unsigned m_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int model_pattern();
        case (m_mode)
            0:       return m_sw;
            1:       return (m_sw & ~1) | int'(m_hb);
            2:       return 1 << ((m_idx < N) ? m_idx : CHASE_LEN - m_idx);
            default: return m_blink ? ((1 << N) - 1) : 0;
        endcase
    endfunction

    function automatic int unsigned model_read(input int a);
        case (a)
            0:       return (m_bright << 8) | (int'(m_irqen) << 3) | (m_mode << 1) | int'(m_en);
            1:       return m_sw;
            2:       return m_period;
            default: return (int'(m_pend) << 31) | m_cnt;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_mode = 0; m_irqen = 0; m_sw = 0; m_period = 250; m_cnt = 0; m_pend = 0;
`ifdef LED_PWM_EN
        m_bright = 255;
`else
        m_bright = 0;
`endif
        m_pcnt = 0; m_scnt = 0; m_idx = 0; m_hb = 0; m_blink = 0; m_pwm = 0;
        m_led = 0; m_irq = 0; m_rdata = 0; m_rvalid = 0;
    endtask

    task automatic model_step(input bit rst, input int a, input bit rd, input bit wr, input logic [31:0] wd);
        bit pwm_on, tick, step, restart, bounce;
        int eff, n_led;
        bit n_irq;
        if (rst) begin
            model_reset();
            return;
        end
`ifdef LED_PWM_EN
        pwm_on = (m_pwm < m_bright);
`else
        pwm_on = 1;
`endif
        n_led = m_en ? (model_pattern() & (pwm_on ? ((1 << N) - 1) : 0)) : 0;
        n_irq = m_pend & m_irqen;
        if (rd && !wr) begin
            m_rdata = model_read(a);
            m_rvalid = 1;
        end else begin
            m_rvalid = 0;
        end
        tick = (m_pcnt == DIV - 1);
        eff = (m_period == 0) ? 1 : m_period;
        step = tick && (m_scnt + 1 >= eff);
        restart = wr && (a == 0) && ((int'(wd[0]) != int'(m_en)) || (int'(wd[2:1]) != m_mode));
        bounce = 0;
        if (restart) begin
            m_pcnt = 0; m_scnt = 0; m_idx = 0; m_hb = 0; m_blink = 0;
        end else begin
            m_pcnt = tick ? 0 : m_pcnt + 1;
            m_scnt = step ? 0 : (tick ? m_scnt + 1 : m_scnt);
            if (step && m_en) begin
                case (m_mode)
                    1: m_hb = ~m_hb;
                    2: begin
                        m_idx = (m_idx + 1) % CHASE_LEN;
                        bounce = (m_idx == 0);
                    end
                    3: m_blink = ~m_blink;
                    default: ;
                endcase
            end
        end
        if (wr && a == 3 && wd[15:0] != 16'd0) m_cnt = 0;
        if (bounce && m_cnt < 65535) m_cnt++;
        if (bounce && m_irqen)           m_pend = 1;
        else if (wr && a == 3 && wd[31]) m_pend = 0;
        if (wr && a == 0) begin
            m_en = wd[0]; m_mode = int'(wd[2:1]); m_irqen = wd[3];
`ifdef LED_PWM_EN
            m_bright = int'(wd[15:8]);
`endif
        end
        if (wr && a == 1) m_sw = int'(wd[N-1:0]);
        if (wr && a == 2) m_period = int'(wd[15:0]);
        m_pwm = (m_pwm + 1) % 256;
        m_led = n_led;
        m_irq = n_irq;
    endtask

    // One bus cycle: drive, clock, advance model, then compare all outputs.
    task automatic cyc(input bit rst, input int a, input bit rd, input bit wr, input logic [31:0] wd);
        reset_reset = rst; avs_address = 2'(a); avs_read = rd; avs_write = wr; avs_writedata = wd;
        @(posedge clk);
        model_step(rst, a, rd, wr, wd);
        #1;
        reset_reset = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
        check_eq("led_out", 32'(led_out), 32'(m_led));
        check_eq("irq", 32'(irq), 32'(m_irq));
        check_eq("readdatavalid", 32'(avs_readdatavalid), 32'(m_rvalid));
        check_eq("readdata", avs_readdata, m_rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'd0);
    endtask

    task automatic wr_reg(input int a, input logic [31:0] d);
        cyc(0, a, 0, 1, d);
    endtask

    task automatic rd_reg(input int a);
        cyc(0, a, 1, 0, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, on_cnt, other;
        int chase_exp [7] = '{1, 2, 4, 8, 4, 2, 1};
        logic [31:0] ctrl_rst;
`ifdef LED_PWM_EN
        ctrl_rst = 32'h0000FF00;
`else
        ctrl_rst = 32'h0;
`endif
        // Reset state and register defaults
        cyc(1, 0, 0, 0, 32'd0);
        check_eq("waitrequest", 32'(avs_waitrequest), 32'd0);
        rd_reg(0); check_eq("rst_ctrl", avs_readdata, ctrl_rst);
        rd_reg(1); check_eq("rst_swval", avs_readdata, 32'd0);
        rd_reg(2); check_eq("rst_period", avs_readdata, 32'd250);
        rd_reg(3); check_eq("rst_status", avs_readdata, 32'd0);
        check_eq("rst_led", 32'(led_out), 32'd0);

        // Chase sequence at one step per cycle, bounce count
        cyc(1, 0, 0, 0, 32'd0);
        wr_reg(2, 32'd1);
        wr_reg(0, 32'h0000FF05);
        for (int i = 0; i < 7; i++) begin
            idle(1);
            check_eq("chase_seq", 32'(led_out), 32'(chase_exp[i]));
        end
        rd_reg(3); check_eq("status_bounce", avs_readdata, 32'd1);

        // irq rise, clear, and clear coinciding with a bounce
        cyc(1, 0, 0, 0, 32'd0);
        wr_reg(2, 32'd1);
        wr_reg(0, 32'h0000FF0D);
        k = 0; while (irq !== 1'b1 && k < 20) begin idle(1); k++; end
        check_eq("irq_rise", 32'(irq), 32'd1);
        wr_reg(3, 32'h80000000);
        idle(1);
        check_eq("irq_clear", 32'(irq), 32'd0);
        k = 0; while (irq !== 1'b1 && k < 20) begin idle(1); k++; end
        check_eq("irq_rise2", 32'(irq), 32'd1);
        k = 0; while (m_idx != CHASE_LEN - 1 && k < 20) begin idle(1); k++; end
        wr_reg(3, 32'h80000000);
        idle(2);
        check_eq("irq_set_wins", 32'(irq), 32'd1);

        // SW mode with brightness
        cyc(1, 0, 0, 0, 32'd0);
        wr_reg(1, 32'hA);
        wr_reg(0, 32'h00004001);
        idle(1);
        on_cnt = 0; other = 0;
        for (int i = 0; i < 256; i++) begin
            idle(1);
            if (led_out == 4'hA) on_cnt++; else if (led_out != 4'h0) other++;
        end
`ifdef LED_PWM_EN
        check_eq("pwm_duty_40", 32'(on_cnt), 32'd64);
`else
        check_eq("pwm_duty_40", 32'(on_cnt), 32'd256);
`endif
        check_eq("pwm_pattern", 32'(other), 32'd0);
        wr_reg(0, 32'h00000001);
        idle(1);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            idle(1);
            if (led_out != 4'h0) on_cnt++;
        end
`ifdef LED_PWM_EN
        check_eq("pwm_duty_0", 32'(on_cnt), 32'd0);
`else
        check_eq("pwm_duty_0", 32'(on_cnt), 32'd256);
`endif

        // Blink with PERIOD 3, then PERIOD 0, then restart by mode rewrite
        cyc(1, 0, 0, 0, 32'd0);
        wr_reg(2, 32'd3);
        wr_reg(0, 32'h0000FF07);
        idle(12);
        wr_reg(2, 32'd0);
        idle(6);
        wr_reg(0, 32'h0000FF05);
        wr_reg(0, 32'h0000FF07);
        idle(1);
        check_eq("blink_restart_off", 32'(led_out), 32'd0);
        idle(1);
        check_eq("blink_on", 32'(led_out), 32'hF);
        idle(1);
        check_eq("blink_off", 32'(led_out), 32'd0);

        // Reset mid-chase, then same-cycle read and write
        cyc(1, 0, 0, 0, 32'd0);
        wr_reg(2, 32'd1);
        wr_reg(0, 32'h0000FF0D);
        k = 0; while ((m_cnt == 0 || led_out !== 4'h4) && k < 30) begin idle(1); k++; end
        check_eq("wait_chase_0100", 32'(led_out), 32'h4);
        cyc(1, 0, 0, 0, 32'd0);
        check_eq("midrst_led", 32'(led_out), 32'd0);
        check_eq("midrst_irq", 32'(irq), 32'd0);
        rd_reg(3); check_eq("midrst_status", avs_readdata, 32'd0);
        cyc(0, 1, 1, 1, 32'h5);
        check_eq("rw_no_valid", 32'(avs_readdatavalid), 32'd0);
        rd_reg(1); check_eq("rw_write_lands", avs_readdata, 32'h5);

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            int a;
            bit rd, wr, rst;
            logic [31:0] wd;
            rst = ($urandom_range(0, 199) == 0);
            a = $urandom_range(0, 3);
            rd = ($urandom_range(0, 3) == 0);
            wr = ($urandom_range(0, 4) == 0);
            case (a)
                0: wd = {$urandom_range(0, 1) ? 16'hFFFF : 16'(($urandom)), 8'($urandom), 4'($urandom),
                         1'($urandom), 2'($urandom), 1'($urandom_range(0, 7) != 0)};
                2: wd = ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 5));
                3: wd = $urandom_range(0, 1) ? ($urandom & 32'h80000000) : $urandom;
                default: wd = $urandom;
            endcase
            cyc(rst, a, rd, wr, wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
